// File: rtl/tanh_act_pkg.sv
// Shared types and quantization helper for the 4-bit tanh input path.
// Used by tanh_in_quant_stream and tanh_code_fifo.
package tanh_act_pkg;

   localparam int CODE_W = 4;
   localparam logic [CODE_W-1:0] CODE_ZERO = 4'd8;
   localparam logic [CODE_W-1:0] CODE_MIN = 4'd0;
   localparam logic [CODE_W-1:0] CODE_MAX = 4'd15;

   typedef logic signed [CODE_W:0] sat_lim_t;

   localparam sat_lim_t SAT_MIN = -5'sd8;
   localparam sat_lim_t SAT_MAX = 5'sd7;

   typedef struct packed {
      logic              last;
      logic [CODE_W-1:0] code;
   } code_ent_t;

   typedef struct packed {
      logic              clamped;
      logic [CODE_W-1:0] code;
   } quant_t;

   // Round half up, arithmetic shift, clamp to [-8,7], offset by +8.
   function automatic quant_t sat_round(
      input logic signed [63:0] acc,
      input int                 shift
   );
      logic signed [63:0] sum;
      logic signed [63:0] q;
      quant_t             r;
      sum = acc + (64'sd1 <<< (shift - 1));
      q = sum >>> shift;
      r.clamped = 1'b0;
      r.code = CODE_ZERO;
      if (q < 64'(SAT_MIN)) begin
         r.clamped = 1'b1;
         r.code = CODE_MIN;
      end else if (q > 64'(SAT_MAX)) begin
         r.clamped = 1'b1;
         r.code = CODE_MAX;
      end else begin
         r.code = q[CODE_W-1:0] + CODE_ZERO;
      end
      return r;
   endfunction

endpackage

// File: rtl/tanh_code_fifo.sv
// Small FIFO of {last, code} entries with registered storage.
// Async active-low reset, synchronous clear with priority.
module tanh_code_fifo
   import tanh_act_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  code_ent_t        wdata,
   output code_ent_t        rdata,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   code_ent_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop_ok;
   logic             push_ok;
   logic             full;

   assign full    = (count == CNT_W'(DEPTH));
   assign valid   = (count != '0);
   assign pop_ok  = pop & valid;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so pointer increment wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (!clear && push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/tanh_in_quant_stream.sv
// Quantizes accumulator samples to 4-bit offset-binary tanh input codes.
// Optional saturation statistics under TANH_IN_QUANT_STATS_EN.
module tanh_in_quant_stream
   import tanh_act_pkg::*;
#(
   parameter int ACC_W = 12,
   parameter int SHIFT = 4,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [ACC_W-1:0] in_acc,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CODE_W-1:0]       out_code,
   output logic                    out_last,
   output logic [CNT_W-1:0]        count
`ifdef TANH_IN_QUANT_STATS_EN
  ,output logic [15:0]             sat_cnt,
   output logic                    sat_flag
`endif
);

   logic      run_q;
   logic      push;
   logic      pop;
   quant_t    qv;
   code_ent_t wdata;
   code_ent_t rdata;

   // Holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else run_q <= 1'b1;
   end

   assign qv       = sat_round(64'(in_acc), SHIFT);
   assign wdata    = '{last: in_last, code: qv.code};
   assign in_ready = run_q & ~clear &
                     ((count < CNT_W'(DEPTH)) | out_ready);
   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   assign out_code = rdata.code;
   assign out_last = rdata.last;

   tanh_code_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .valid (out_valid),
      .count (count)
   );

`ifdef TANH_IN_QUANT_STATS_EN
   logic vec_sat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt   <= '0;
         sat_flag  <= 1'b0;
         vec_sat_q <= 1'b0;
      end else if (clear) begin
         sat_cnt   <= '0;
         sat_flag  <= 1'b0;
         vec_sat_q <= 1'b0;
      end else if (push) begin
         if (qv.clamped && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
         if (in_last) begin
            sat_flag  <= vec_sat_q | qv.clamped;
            vec_sat_q <= 1'b0;
         end else begin
            sat_flag  <= 1'b0;
            vec_sat_q <= vec_sat_q | qv.clamped;
         end
      end
   end
`else
   logic stats_unused;
   assign stats_unused = qv.clamped;
`endif

endmodule

// File: tb/tb_tanh_in_quant_stream.sv
// Directed plus randomized bench for tanh_in_quant_stream.
// Checks against a queue-based model derived from integer arithmetic.
module tb_tanh_in_quant_stream;

   localparam int ACC_W = 12;
   localparam int DEPTH = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    clear;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [ACC_W-1:0] in_acc;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [3:0]              out_code;
   logic                    out_last;
   logic [1:0]              count;
`ifdef TANH_IN_QUANT_STATS_EN
   logic [15:0]             sat_cnt;
   logic                    sat_flag;
`endif

   int       checks = 0;
   int       errors = 0;
   logic [4:0] mq[$];
   bit       was_acc;
   int       m_cnt;
   bit       m_vec;
   bit       m_flag;

   tanh_in_quant_stream #(
      .ACC_W (ACC_W),
      .SHIFT (4),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_acc    (in_acc),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_last  (out_last),
      .count     (count)
`ifdef TANH_IN_QUANT_STATS_EN
     ,.sat_cnt   (sat_cnt),
      .sat_flag  (sat_flag)
`endif
   );

   always #5 clk = ~clk;

   function automatic int ref_q(int acc);
      int sum;
      sum = acc + 8;
      if (sum >= 0) return sum / 16;
      return -((-sum + 15) / 16);
   endfunction

   function automatic logic [3:0] ref_code(int acc);
      int q;
      q = ref_q(acc);
      if (q < -8) q = -8;
      if (q > 7) q = 7;
      return 4'(q + 8);
   endfunction

   function automatic bit ref_clamp(int acc);
      int q;
      q = ref_q(acc);
      return (q < -8) || (q > 7);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_stats();
`ifdef TANH_IN_QUANT_STATS_EN
      chk("sat_cnt", 32'(sat_cnt), 32'(m_cnt));
      chk("sat_flag", 32'(sat_flag), 32'(m_flag));
`endif
   endtask

   // Entered at posedge+1; leaves at the next posedge+1.
   task automatic cycle(input bit v, input int acc, input bit last,
                        input bit ordy, input bit clr);
      bit rdy;
      bit pop;
      int a;
      in_valid  = v;
      in_acc    = ACC_W'(acc);
      in_last   = last;
      out_ready = ordy;
      clear     = clr;
      #1;
      a = int'(in_acc);
      rdy = !clr && (mq.size() < DEPTH || ordy);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      was_acc = v && rdy;
      pop = (mq.size() != 0) && ordy;
      @(posedge clk);
      #1;
      if (clr) begin
         mq.delete();
         m_cnt = 0;
         m_vec = 0;
         m_flag = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (was_acc) begin
            mq.push_back({last, ref_code(a)});
            if (ref_clamp(a) && m_cnt < 65535) m_cnt++;
            if (last) begin
               m_flag = m_vec | ref_clamp(a);
               m_vec = 0;
            end else begin
               m_flag = 0;
               m_vec = m_vec | ref_clamp(a);
            end
         end
      end
      chk("count", 32'(count), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("out_code", 32'(out_code), 32'(mq[0][3:0]));
         chk("out_last", 32'(out_last), 32'(mq[0][4]));
      end
      chk_stats();
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_out_code"}, 32'(out_code), 32'd0);
      chk({tag, "_out_last"}, 32'(out_last), 32'd0);
      chk_stats();
   endtask

   initial begin
      int accs[5];
      int codes[5];
      int p_acc;
      bit p_last;
      bit p_v;
      accs  = '{-8, -9, -200, 2047, -2048};
      codes = '{8, 7, 0, 15, 0};
      m_cnt = 0;
      m_vec = 0;
      m_flag = 0;
      rst_n = 1'b0;
      clear = 1'b0;
      in_valid = 1'b0;
      in_acc = '0;
      in_last = 1'b0;
      out_ready = 1'b0;
      #12;
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      cycle(1, 40, 0, 1, 0);
      chk("first_code", 32'(out_code), 32'hB);
      chk("first_count", 32'(count), 32'd1);

      for (int i = 0; i < 5; i++) begin
         cycle(1, accs[i], 0, 1, 0);
         chk("round", 32'(out_code), 32'(codes[i]));
      end
      cycle(0, 0, 0, 1, 0);

      cycle(1, 100, 0, 0, 0);
      cycle(1, 200, 0, 0, 0);
      cycle(1, 300, 0, 0, 0);
      chk("bp_full", 32'(count), 32'd2);
      chk("bp_held", 32'(in_ready), 32'd0);
      cycle(1, 300, 0, 1, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);

      cycle(1, 16, 0, 0, 0);
      cycle(1, 32, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cycle(1, 16 * i - 40, 0, 1, 0);
         chk("tput_count", 32'(count), 32'd2);
      end
      for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0);

      for (int i = 0; i < 4; i++) begin
         cycle(1, 20 * i, i == 3, 1, 0);
         chk("vec_last", 32'(out_last), 32'(i == 3));
      end
      cycle(0, 0, 0, 1, 0);

      cycle(1, 70, 0, 0, 0);
      cycle(1, 80, 0, 0, 0);
      cycle(1, 90, 0, 0, 1);
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_valid", 32'(out_valid), 32'd0);

      p_v = 1;
      p_acc = int'($urandom_range(4095)) - 2048;
      p_last = 1'($urandom_range(1));
      for (int i = 0; i < 300; i++) begin
         cycle(p_v, p_acc, p_last, 1'($urandom_range(1)), 0);
         if (was_acc || !p_v) begin
            p_v = ($urandom_range(3) != 0);
            p_acc = int'($urandom_range(4095)) - 2048;
            p_last = ($urandom_range(3) == 0);
         end
      end

      cycle(1, 500, 0, 0, 0);
      cycle(1, -500, 1, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      mq.delete();
      m_cnt = 0;
      m_vec = 0;
      m_flag = 0;
      chk_reset_vals("midrst");
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1, 7, 0, 1, 0);
      chk("post_rst_code", 32'(out_code), 32'h8);

`ifdef TANH_IN_QUANT_STATS_EN
      cycle(0, 0, 0, 1, 1);
      cycle(1, 2047, 0, 1, 0);
      cycle(1, 5, 0, 1, 0);
      cycle(1, -3000, 1, 1, 0);
      chk("stats_cnt", 32'(sat_cnt), 32'd2);
      chk("stats_flag", 32'(sat_flag), 32'd1);
      cycle(0, 0, 0, 1, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tanh_in_quant_stream.md
Name: tanh_in_quant_stream

Overview:
- Streaming front-end stage directly upstream of the 4-bit tanh activation circuits.
- Accepts signed MAC accumulator samples over a valid/ready handshake, then rounds, scales and saturates each one to the 4-bit offset-binary input code those circuits consume.
- Buffers the codes in a small FIFO so the activation-stream can apply backpressure without losing samples.
- Carries a last-of-vector marker alongside each code.

Parameters:
- ACC_W, 12, width of signed accumulator input (≥ SHIFT+5).
- SHIFT, 4, right-shift (fractional bits discarded) before saturation; ≥1.
- DEPTH, 2, output FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush: empties FIFO, drops pipeline sample.
- in_valid  input  1  in_acc/in_last valid.
- in_ready  output  1  stage can accept this cycle.
- in_acc  input  ACC_W  signed accumulator sample.
- in_last  input  1  final sample of vector.
- out_valid  output  1  out_code/out_last valid.
- out_ready  input  1  consumer accepts.
- out_code  output  4  offset-binary code, drives the tanh circuit's In[3:0].
- out_last  output  1  last marker of out_code.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, async): FIFO empty, pointers 0, count 0, out_valid 0, out_code 4'h0, out_last 0, in_ready 0 while rst_n low. in_ready rises in the first cycle after deassertion.
- Quantization:
  - sum = sext(in_acc, ACC_W+1) + 2^(SHIFT-1), round half up.
  - q = sum >>> SHIFT (arithmetic).
  - s = clamp(q, -8, +7).
  - out_code = s + 8, so 0 = most negative, 8 = zero, 15 = most positive.
  - Combinational at the input. The code is written into the FIFO on the accept edge.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output pop = out_valid & out_ready.
  - in_ready = (count < DEPTH) | out_ready. A simultaneous push and pop at full is allowed.
  - in_valid may be held across stalls; in_acc must stay stable while in_valid is high and in_ready is low.
- Latency: a sample accepted at edge N is visible on out_code with out_valid=1 after edge N if the FIFO was empty. Throughput is 1 sample/cycle sustained.
- FIFO: registered outputs; out_code/out_last come from the head entry; out_valid = (count != 0).
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop: count unchanged, head advances.
  - Pointers wrap modulo DEPTH.
- Empty: out_valid 0; out_code holds its last value (don't-care for checking). Push and pop in the same cycle is not possible when empty.
- Full with out_ready low: in_ready 0; the input is held off and no overwrite occurs.
- clear:
  - Takes priority over push/pop: count→0, pointers→0, out_valid→0 next cycle.
  - in_ready is forced to 0 during the clear cycle, so no sample is accepted.
- Reset mid-stream discards all buffered samples. No partial vector is replayed.

Optional Feature:
- Macro TANH_IN_QUANT_STATS_EN.
- Defined:
  - Adds output sat_cnt[15:0], incremented on each accepted sample whose q was clamped, saturating at 16'hFFFF.
  - Adds output sat_flag, set when an accepted sample with in_last=1 belongs to a vector containing any clamp, and cleared at the next accepted sample.
  - Both are reset to 0 by rst_n and by clear.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package tanh_act_pkg: CODE_W=4, CODE_ZERO=4'd8, CODE_MIN=4'd0, CODE_MAX=4'd15, a signed saturation-limits typedef, and a function sat_round() implementing the quantization for reuse by the scoreboard.
- One sub-module: tanh_code_fifo (parameterized DEPTH, 5-bit entries {last, code}, async active-low reset, sync clear).

Test Plan:
- After reset release, in_acc=12'sd40 valid, out_ready=1 → next cycle out_valid=1, out_code=4'hB, count=1.
- Rounding and saturation, in order: in_acc=-8 → 8; -9 → 7; -200 → 0; 2047 → 15; -2048 → 0.
- out_ready=0 with 3 back-to-back valid samples (DEPTH=2) → in_ready drops after 2 accepts, count=2. Raise out_ready → codes drain in order, none lost or duplicated.
- Full FIFO, in_valid=1, out_ready=1 every cycle → 1/cycle throughput, count stays 2, in_ready stays 1.
- in_last=1 on the 4th of 4 samples → out_last=1 only with the 4th code.
- Assert clear while count=2 → next cycle out_valid=0, count=0, and no accept during the clear cycle.
- Assert rst_n low mid-stream → outputs go to reset values immediately, without a clock edge.
- With TANH_IN_QUANT_STATS_EN: vector {2047, 5, -3000 last} → sat_cnt=2 and sat_flag=1 after the last sample.
